// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot-time checker.
package sysid_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      FIN   = 2'd3
   } sysid_state_e;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   // Width of the per-read stall counter.
   localparam int SYSID_CNT_W = 16;

endpackage

// File: rtl/sysid_stall_timer.sv
// Saturating stall counter for boot-time bus probes. A read may stall for up
// to TIMEOUT_CYCLES cycles; expired_o flags that the budget is used up, so a
// further stalled cycle is the one that aborts.
module sysid_stall_timer
   import sysid_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [SYSID_CNT_W-1:0] LIMIT   = SYSID_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [SYSID_CNT_W-1:0] CNT_MAX = '1;

   logic [SYSID_CNT_W-1:0] cnt_q;

   // Count stalled cycles; clear has priority and the count never wraps.
   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         cnt_q <= '0;
      end else if (enable_i && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// Boot-time sequencer: reads the ID and timestamp words from the system-ID
// slave, compares them to build-time values and reports match/timeout status.
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'h6689_C57B,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] read_id,
   output logic [31:0] read_ts
);

   sysid_state_e state_q, state_d;
   logic         auto_q, auto_d;
   logic         id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
   logic [31:0]  read_id_q, read_id_d, read_ts_q, read_ts_d;
   logic         avm_read_q, avm_address_q, busy_q, done_q;
   logic         tmr_clear, tmr_enable, tmr_expired;

   assign tmr_enable = ((state_q == RD_ID) || (state_q == RD_TS)) && avm_waitrequest;

   sysid_stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (tmr_clear),
      .enable_i  (tmr_enable),
      .expired_o (tmr_expired)
   );

   // Next-state and result-update logic for the read sequence.
   always_comb begin
      state_d   = state_q;
      auto_d    = auto_q;
      id_ok_d   = id_ok_q;
      ts_ok_d   = ts_ok_q;
      timeout_d = timeout_q;
      read_id_d = read_id_q;
      read_ts_d = read_ts_q;
      tmr_clear = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_clear = 1'b1;
            if (start || auto_q) begin
               state_d   = RD_ID;
               auto_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end
         RD_ID: begin
            if (!avm_waitrequest) begin
               read_id_d = avm_readdata;
               id_ok_d   = (avm_readdata == EXPECTED_ID);
               tmr_clear = 1'b1;
               state_d   = RD_TS;
            end else if (tmr_expired) begin
               timeout_d = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               state_d   = FIN;
            end
         end
         RD_TS: begin
            if (!avm_waitrequest) begin
               read_ts_d = avm_readdata;
               ts_ok_d   = (avm_readdata == EXPECTED_TS);
               state_d   = FIN;
            end else if (tmr_expired) begin
               timeout_d = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               state_d   = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, results and registered bus/status outputs decoded from next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         auto_q        <= AUTO_START;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         read_id_q     <= '0;
         read_ts_q     <= '0;
         avm_read_q    <= 1'b0;
         avm_address_q <= SYSID_ADDR_ID;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         auto_q        <= auto_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         read_id_q     <= read_id_d;
         read_ts_q     <= read_ts_d;
         avm_read_q    <= (state_d == RD_ID) || (state_d == RD_TS);
         avm_address_q <= (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
         busy_q        <= (state_d != IDLE);
         done_q        <= (state_d == FIN);
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign read_id     = read_id_q;
   assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: instance A auto-starts with a long stall
// budget, instance B waits for start and has a 4-cycle stall budget.
`timescale 1ns/1ps
module tb_sysid_checker;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] TS_OK = 32'h6689_C57B;
   localparam logic [31:0] ID_B  = 32'hCAFE_0001;

   logic        rst_a, start_a, wait_a, addr_a, rd_a, busy_a, done_a, idok_a, tsok_a, to_a;
   logic [31:0] rdata_a, rid_a, rts_a, mid_a, mts_a;
   logic        rst_b, start_b, wait_b, addr_b, rd_b, busy_b, done_b, idok_b, tsok_b, to_b;
   logic [31:0] rdata_b, rid_b, rts_b, mid_b, mts_b;

   // Combinational slave models.
   assign rdata_a = addr_a ? mts_a : mid_a;
   assign rdata_b = addr_b ? mts_b : mid_b;

   sysid_checker #(.EXPECTED_ID(32'h0), .EXPECTED_TS(TS_OK), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u_a (
      .clock(clock), .reset(rst_a), .start(start_a), .avm_address(addr_a), .avm_read(rd_a),
      .avm_readdata(rdata_a), .avm_waitrequest(wait_a), .busy(busy_a), .done(done_a),
      .id_ok(idok_a), .ts_ok(tsok_a), .timeout(to_a), .read_id(rid_a), .read_ts(rts_a));

   sysid_checker #(.EXPECTED_ID(ID_B), .EXPECTED_TS(TS_OK), .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) u_b (
      .clock(clock), .reset(rst_b), .start(start_b), .avm_address(addr_b), .avm_read(rd_b),
      .avm_readdata(rdata_b), .avm_waitrequest(wait_b), .busy(busy_b), .done(done_b),
      .id_ok(idok_b), .ts_ok(tsok_b), .timeout(to_b), .read_id(rid_b), .read_ts(rts_b));

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset;
      cyc(3);
      total++; if ({rd_a, addr_a, busy_a, done_a, idok_a, tsok_a, to_a} !== 7'b0) begin
         bad++; $display("FAIL reset_a_status got=%b exp=%b", {rd_a, addr_a, busy_a, done_a, idok_a, tsok_a, to_a}, 7'b0); end
      total++; if ({rid_a, rts_a} !== 64'h0) begin
         bad++; $display("FAIL reset_a_data got=%h exp=%h", {rid_a, rts_a}, 64'h0); end
      total++; if ({rd_b, addr_b, busy_b, done_b, idok_b, tsok_b, to_b} !== 7'b0) begin
         bad++; $display("FAIL reset_b_status got=%b exp=%b", {rd_b, addr_b, busy_b, done_b, idok_b, tsok_b, to_b}, 7'b0); end
      // Release A before edge N; auto-start launches the check at edge N.
      rst_a = 1'b0;
      rst_b = 1'b0;
      cyc();
      total++; if ({rd_a, addr_a, busy_a, done_a} !== 4'b1010) begin
         bad++; $display("FAIL auto_rd_id got=%b exp=%b", {rd_a, addr_a, busy_a, done_a}, 4'b1010); end
      cyc();
      total++; if ({rd_a, addr_a, busy_a, done_a} !== 4'b1110) begin
         bad++; $display("FAIL auto_rd_ts got=%b exp=%b", {rd_a, addr_a, busy_a, done_a}, 4'b1110); end
      cyc();
      total++; if ({rd_a, busy_a, done_a, idok_a, tsok_a, to_a} !== 6'b011110) begin
         bad++; $display("FAIL auto_done got=%b exp=%b", {rd_a, busy_a, done_a, idok_a, tsok_a, to_a}, 6'b011110); end
      total++; if ({rid_a, rts_a} !== {32'h0, TS_OK}) begin
         bad++; $display("FAIL auto_data got=%h exp=%h", {rid_a, rts_a}, {32'h0, TS_OK}); end
      cyc();
      total++; if ({busy_a, done_a, idok_a, tsok_a} !== 4'b0011) begin
         bad++; $display("FAIL auto_idle got=%b exp=%b", {busy_a, done_a, idok_a, tsok_a}, 4'b0011); end
      total++; if ({rd_b, busy_b} !== 2'b00) begin
         bad++; $display("FAIL b_no_autostart got=%b exp=%b", {rd_b, busy_b}, 2'b00); end
   endtask

   task automatic test_mismatch;
      mts_a = 32'h6689_C57C;
      start_a = 1'b1; cyc(); start_a = 1'b0;
      cyc(2);
      total++; if ({done_a, idok_a, tsok_a, to_a} !== 4'b1100) begin
         bad++; $display("FAIL ts_mismatch_flags got=%b exp=%b", {done_a, idok_a, tsok_a, to_a}, 4'b1100); end
      total++; if (rts_a !== 32'h6689_C57C) begin
         bad++; $display("FAIL ts_mismatch_data got=%h exp=%h", rts_a, 32'h6689_C57C); end
      cyc();
      mts_a = TS_OK;
      mid_a = 32'h0000_0001;
      start_a = 1'b1; cyc(); start_a = 1'b0;
      cyc(2);
      total++; if ({done_a, idok_a, tsok_a, to_a} !== 4'b1010) begin
         bad++; $display("FAIL id_mismatch_flags got=%b exp=%b", {done_a, idok_a, tsok_a, to_a}, 4'b1010); end
      total++; if ({rid_a, rts_a} !== {32'h1, TS_OK}) begin
         bad++; $display("FAIL id_mismatch_data got=%h exp=%h", {rid_a, rts_a}, {32'h1, TS_OK}); end
      cyc();
      mid_a = 32'h0;
   endtask

   task automatic test_ts_stall;
      start_a = 1'b1; cyc(); start_a = 1'b0;
      cyc();
      wait_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++; if ({rd_a, addr_a, busy_a, done_a} !== 4'b1110) begin
            bad++; $display("FAIL ts_stall_hold%0d got=%b exp=%b", i, {rd_a, addr_a, busy_a, done_a}, 4'b1110); end
         cyc();
      end
      wait_a = 1'b0;
      total++; if ({rd_a, addr_a, done_a} !== 3'b110) begin
         bad++; $display("FAIL ts_stall_accept got=%b exp=%b", {rd_a, addr_a, done_a}, 3'b110); end
      cyc();
      total++; if ({done_a, idok_a, tsok_a, to_a} !== 4'b1110) begin
         bad++; $display("FAIL ts_stall_done got=%b exp=%b", {done_a, idok_a, tsok_a, to_a}, 4'b1110); end
      cyc();
   endtask

   task automatic test_start_ignored;
      start_a = 1'b1; cyc(); start_a = 1'b0;
      cyc();
      start_a = 1'b1;
      cyc();
      total++; if (done_a !== 1'b1) begin
         bad++; $display("FAIL ign_done got=%b exp=%b", done_a, 1'b1); end
      cyc();
      start_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if ({rd_a, busy_a, done_a} !== 3'b000) begin
            bad++; $display("FAIL ign_idle%0d got=%b exp=%b", i, {rd_a, busy_a, done_a}, 3'b000); end
         cyc();
      end
   endtask

   task automatic test_timeout;
      start_b = 1'b1; cyc(); start_b = 1'b0;
      cyc(2);
      total++; if ({done_b, idok_b, tsok_b, rid_b} !== {3'b111, ID_B}) begin
         bad++; $display("FAIL b_good got=%h exp=%h", {done_b, idok_b, tsok_b, rid_b}, {3'b111, ID_B}); end
      cyc();
      mid_b = 32'hDEAD_BEEF;
      wait_b = 1'b1;
      start_b = 1'b1; cyc(); start_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++; if ({rd_b, addr_b, busy_b, done_b, idok_b, to_b} !== 6'b101000) begin
            bad++; $display("FAIL to_stall%0d got=%b exp=%b", i, {rd_b, addr_b, busy_b, done_b, idok_b, to_b}, 6'b101000); end
         cyc();
      end
      total++; if ({rd_b, busy_b, done_b, idok_b, tsok_b, to_b} !== 6'b011001) begin
         bad++; $display("FAIL to_done got=%b exp=%b", {rd_b, busy_b, done_b, idok_b, tsok_b, to_b}, 6'b011001); end
      total++; if ({rid_b, rts_b} !== {ID_B, TS_OK}) begin
         bad++; $display("FAIL to_data_kept got=%h exp=%h", {rid_b, rts_b}, {ID_B, TS_OK}); end
      wait_b = 1'b0;
      cyc();
      total++; if ({busy_b, to_b} !== 2'b01) begin
         bad++; $display("FAIL to_idle got=%b exp=%b", {busy_b, to_b}, 2'b01); end
   endtask

   task automatic test_reset_mid;
      mid_b = ID_B;
      wait_b = 1'b1;
      start_b = 1'b1; cyc(); start_b = 1'b0;
      cyc();
      total++; if (rd_b !== 1'b1) begin
         bad++; $display("FAIL rm_in_stall got=%b exp=%b", rd_b, 1'b1); end
      rst_b = 1'b1;
      cyc();
      total++; if ({rd_b, busy_b, done_b, idok_b, tsok_b, to_b} !== 6'b0) begin
         bad++; $display("FAIL rm_status got=%b exp=%b", {rd_b, busy_b, done_b, idok_b, tsok_b, to_b}, 6'b0); end
      total++; if ({rid_b, rts_b} !== 64'h0) begin
         bad++; $display("FAIL rm_data got=%h exp=%h", {rid_b, rts_b}, 64'h0); end
      rst_b = 1'b0;
      wait_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         total++; if ({rd_b, busy_b, done_b} !== 3'b000) begin
            bad++; $display("FAIL rm_idle%0d got=%b exp=%b", i, {rd_b, busy_b, done_b}, 3'b000); end
      end
      start_b = 1'b1; cyc(); start_b = 1'b0;
      cyc(2);
      total++; if ({done_b, idok_b, tsok_b, to_b} !== 4'b1110) begin
         bad++; $display("FAIL rm_restart got=%b exp=%b", {done_b, idok_b, tsok_b, to_b}, 4'b1110); end
      cyc();
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      wait_a = 1'b0; wait_b = 1'b0;
      mid_a = 32'h0; mts_a = TS_OK;
      mid_b = ID_B;  mts_b = TS_OK;
      test_reset();
      test_mismatch();
      test_ts_stall();
      test_start_ignored();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
